// File: rtl/fp_scanner.sv
// fp_scanner: front-panel read master. Strobes each source on the shared
// fpd bus in turn, assembles a frame, shifts it MSB-first into the LED
// driver chain, then latches it and publishes it on capture.
module fp_scanner #(
    parameter int NUM_SLOTS     = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    output logic [NUM_SLOTS-1:0]   nfpstrobe,
    input  logic [7:0]             fpd,
    output logic                   sr_data,
    output logic                   sr_clk,
    output logic                   sr_latch,
    output logic [8*NUM_SLOTS-1:0] capture,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int FRAME_BITS = 8 * NUM_SLOTS;
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W      = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_GAP    = 3'd2,
        S_SHIFT  = 3'd3,
        S_LATCH  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [SLOT_W-1:0]       r_slot;
    logic [CNT_W-1:0]        r_cnt;
    logic [BIT_W-1:0]        r_bit;
    logic                    r_phase;
    logic [FRAME_BITS-1:0]   r_shadow;
    logic [FRAME_BITS-1:0]   r_capture;

    state_t                  w_state_next;
    logic [SLOT_W-1:0]       w_slot_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [BIT_W-1:0]        w_bit_next;
    logic                    w_phase_next;
    logic [FRAME_BITS-1:0]   w_shadow_next;
    logic [FRAME_BITS-1:0]   w_capture_next;

    assign capture = r_capture;

    // State and datapath registers; reset forces IDLE at once, which also
    // releases any low strobe without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_slot    <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_phase   <= 1'b0;
            r_shadow  <= '0;
            r_capture <= '0;
        end else begin
            r_state   <= w_state_next;
            r_slot    <= w_slot_next;
            r_cnt     <= w_cnt_next;
            r_bit     <= w_bit_next;
            r_phase   <= w_phase_next;
            r_shadow  <= w_shadow_next;
            r_capture <= w_capture_next;
        end
    end

    // Next-state logic and Moore outputs decoded from the registered state.
    always_comb begin
        w_state_next   = r_state;
        w_slot_next    = r_slot;
        w_cnt_next     = r_cnt;
        w_bit_next     = r_bit;
        w_phase_next   = r_phase;
        w_shadow_next  = r_shadow;
        w_capture_next = r_capture;
        nfpstrobe      = '1;
        sr_data        = 1'b0;
        sr_clk         = 1'b0;
        sr_latch       = 1'b0;
        busy           = 1'b1;
        frame_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // run is only looked at here, so a frame always completes.
                if (run) begin
                    w_state_next = S_STROBE;
                    w_slot_next  = '0;
                    w_cnt_next   = '0;
                end
            end

            S_STROBE: begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (r_slot == SLOT_W'(k)) begin
                        nfpstrobe[k] = 1'b0;
                    end
                end
                if (r_cnt == LAST_CNT) begin
                    // Sample on the edge that ends the last strobe cycle.
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        if (r_slot == SLOT_W'(k)) begin
                            w_shadow_next[8*k +: 8] = fpd;
                        end
                    end
                    w_cnt_next   = '0;
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_GAP: begin
                // All strobes high for a cycle so the last source lets go of fpd.
                if (r_slot < LAST_SLOT) begin
                    w_slot_next  = r_slot + 1'b1;
                    w_state_next = S_STROBE;
                end else begin
                    w_bit_next   = TOP_BIT;
                    w_phase_next = 1'b0;
                    w_state_next = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Bit index only moves after phase 1, so data is steady
                // across the rising edge of sr_clk.
                sr_data      = r_shadow[r_bit];
                sr_clk       = r_phase;
                w_phase_next = ~r_phase;
                if (r_phase) begin
                    if (r_bit == '0) begin
                        // Publish the whole frame so it is valid while
                        // frame_done is high.
                        w_capture_next = r_shadow;
                        w_state_next   = S_LATCH;
                    end else begin
                        w_bit_next = r_bit - 1'b1;
                    end
                end
            end

            S_LATCH: begin
                sr_latch     = 1'b1;
                frame_done   = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fp_scanner.sv
// Directed bench for fp_scanner at default parameters (4 slots, 2-cycle
// strobes). Sources drive fpd only while their strobe is low.
module tb_fp_scanner;

    logic        clk;
    logic        reset;
    logic        run;
    wire  [3:0]  nfpstrobe;
    wire  [7:0]  fpd;
    wire         sr_data;
    wire         sr_clk;
    wire         sr_latch;
    wire  [31:0] capture;
    wire         busy;
    wire         frame_done;

    logic [7:0]  src [4];

    int n_checks;
    int n_pass;

    // Contention / serial monitor state
    int          cont_viol;
    int          sr_viol;
    int          fd_count;
    logic [31:0] sreg;
    logic [31:0] sreg_at_latch;
    logic        prev_sclk;
    logic        prev_sdata;
    logic [3:0]  prev_strobe;

    fp_scanner #(.NUM_SLOTS(4), .STROBE_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .nfpstrobe  (nfpstrobe),
        .fpd        (fpd),
        .sr_data    (sr_data),
        .sr_clk     (sr_clk),
        .sr_latch   (sr_latch),
        .capture    (capture),
        .busy       (busy),
        .frame_done (frame_done)
    );

    assign fpd = !nfpstrobe[0] ? src[0] :
                 !nfpstrobe[1] ? src[1] :
                 !nfpstrobe[2] ? src[2] :
                 !nfpstrobe[3] ? src[3] : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe contention, serial data stability, chain model, frame counter.
    always @(negedge clk) begin
        if ($countones(~nfpstrobe) > 1) cont_viol++;
        if (prev_strobe != 4'hF && nfpstrobe != 4'hF && nfpstrobe != prev_strobe) cont_viol++;
        if (sr_clk && !prev_sclk) begin
            if (sr_data != prev_sdata) sr_viol++;
            sreg = {sreg[30:0], sr_data};
        end
        if (sr_latch) sreg_at_latch = sreg;
        if (frame_done) fd_count++;
        prev_strobe = nfpstrobe;
        prev_sclk   = sr_clk;
        prev_sdata  = sr_data;
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 400);
        check("frame_done_seen", {63'd0, frame_done}, 64'd1);
    endtask

    task automatic wait_sclk(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sr_clk && n < 400);
        check("sr_clk_seen", {63'd0, sr_clk}, 64'd1);
    endtask

    initial begin
        logic [3:0] exp_strobe [12];
        int         n1;
        int         n2;
        int         fd_before;
        logic       activity;
        logic       found;

        exp_strobe = '{4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hF,
                       4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'hF};
        n_checks = 0; n_pass = 0;
        cont_viol = 0; sr_viol = 0; fd_count = 0;
        sreg = '0; sreg_at_latch = '0;
        prev_sclk = 1'b0; prev_sdata = 1'b0; prev_strobe = 4'hF;
        src[0] = 8'hBC; src[1] = 8'h11; src[2] = 8'h22; src[3] = 8'h33;
        reset = 1'b1;
        run   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_strobe", {60'd0, nfpstrobe}, 64'hF);
        check("rst_sr_data", {63'd0, sr_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_capture", {32'd0, capture}, 64'd0);
        reset = 1'b0;

        // Idle with run=0: nothing moves
        activity = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (nfpstrobe != 4'hF || busy || sr_clk || sr_latch) activity = 1'b1;
        end
        check("idle_quiet", {63'd0, activity}, 64'd0);
        check("idle_capture", {32'd0, capture}, 64'd0);

        // Frame 1: strobe sequence cycle by cycle, then frame length
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("strobe_seq%0d", i), {60'd0, nfpstrobe}, {60'd0, exp_strobe[i]});
        end
        wait_done(n1);
        check("frame_len", 64'(12 + n1), 64'd77);
        check("f1_capture", {32'd0, capture}, 64'h332211BC);
        check("f1_sr_latch", {63'd0, sr_latch}, 64'd1);
        #1;
        check("f1_serial", {32'd0, sreg_at_latch}, 64'h332211BC);

        // Frame 2: slot 2 changes mid-SHIFT, must not affect this frame
        wait_sclk(n1);
        src[2] = 8'h55;
        wait_done(n2);
        check("frame_period", 64'(n1 + n2), 64'd78);
        check("f2_capture", {32'd0, capture}, 64'h332211BC);
        #1;
        check("f2_serial", {32'd0, sreg_at_latch}, 64'h332211BC);

        // Frame 3: new slot 2 value seen; run dropped during SHIFT
        wait_sclk(n1);
        run = 1'b0;
        #1;
        fd_before = fd_count;
        wait_done(n2);
        check("f3_capture", {32'd0, capture}, 64'h335511BC);
        #1;
        check("f3_serial", {32'd0, sreg_at_latch}, 64'h335511BC);
        repeat (150) @(negedge clk);
        #1;
        check("stop_one_frame", 64'(fd_count - fd_before), 64'd1);
        check("stop_busy", {63'd0, busy}, 64'd0);
        check("stop_strobe", {60'd0, nfpstrobe}, 64'hF);
        check("stop_capture_held", {32'd0, capture}, 64'h335511BC);

        // Asynchronous reset while slot 1 is strobed
        src[2] = 8'h22;
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (nfpstrobe == 4'hD) found = 1'b1;
        end
        check("strobe1_seen", {63'd0, found}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_strobe_release", {60'd0, nfpstrobe}, 64'hF);
        check("async_capture", {32'd0, capture}, 64'd0);
        check("async_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_done(n1);
        check("post_rst_len", 64'(n1), 64'd77);
        check("post_rst_capture", {32'd0, capture}, 64'h332211BC);
        #1;
        check("post_rst_serial", {32'd0, sreg_at_latch}, 64'h332211BC);
        run = 1'b0;
        repeat (100) @(negedge clk);

        check("contention", 64'(cont_viol), 64'd0);
        check("sr_data_stable", 64'(sr_viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
